// File: rtl/z80_pkg.sv
// Shared Z80 definitions: register-file command encodings, flag bit positions,
// block-sequencer state encoding and block-opcode decode helpers.
package z80_pkg;

    localparam logic [2:0] CMD_NOPE = 3'b000;
    localparam logic [2:0] CMD_INC  = 3'b100;
    localparam logic [2:0] CMD_DEC  = 3'b101;

    localparam int FLAG_SIGN   = 7;
    localparam int FLAG_ZERO   = 6;
    localparam int FLAG_HALF   = 4;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_N      = 1;
    localparam int FLAG_CARRY  = 0;

    // Opcode bits of the ED-prefixed block group (LDI/LDD/CPI/CPD and repeats).
    localparam int OP_CP  = 0;
    localparam int OP_DEC = 3;
    localparam int OP_REP = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    // Valid set is A0,A1,A8,A9,B0,B1,B8,B9: only bits 0, 3 and 4 may vary.
    function automatic logic is_block_op(input logic [7:0] op);
        return (op & 8'hE6) == 8'hA0;
    endfunction

endpackage

// File: rtl/blk_flags.sv
// Flag result of one block-transfer or block-compare step, computed from the
// pre-instruction register values and the byte read from (HL).
module blk_flags
    import z80_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  f,
    input  logic [7:0]  mem_byte,
    input  logic [15:0] bc,
    input  logic [7:0]  opcode,
    output logic [7:0]  flag
);

    logic [7:0]  diff;
    logic [15:0] bc_dec;

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        diff   = a - mem_byte;
        bc_dec = bc - 16'd1;
        flag   = f;
        flag[FLAG_HALF]   = 1'b0;
        flag[FLAG_N]      = 1'b0;
        flag[FLAG_PARITY] = (bc_dec != 16'd0);
        if (opcode[OP_CP]) begin
            flag[FLAG_SIGN] = diff[7];
            flag[FLAG_ZERO] = (diff == 8'd0);
            flag[FLAG_HALF] = (a[3:0] < mem_byte[3:0]);
            flag[FLAG_N]    = 1'b1;
        end
    end

endmodule

// File: rtl/block_seq.sv
// Sequencer for the Z80 ED-prefixed block instructions (LDx/CPx and repeats):
// memory read from HL, optional write to DE, register-file command and flag update.
module block_seq
    import z80_pkg::*;
(
    input  logic        pin_clk,
    input  logic        pin_rst,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] bc,
    input  logic [15:0] de,
    input  logic [15:0] hl,
    input  logic [7:0]  a,
    input  logic [7:0]  f,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic [2:0]  cmd,
    output logic        flg_w,
    output logic [7:0]  flag,
    output logic        busy,
    output logic        done,
    output logic        rep
);

    state_t     state, state_nxt;
    logic [7:0] op_q;
    logic [7:0] byte_q;
    logic       pv_q;
    logic       z_q;
    logic [7:0] flag_calc;

    blk_flags u_flags (
        .a        (a),
        .f        (f),
        .mem_byte (byte_q),
        .bc       (bc),
        .opcode   (op_q),
        .flag     (flag_calc)
    );

    // P/V and Z are captured in UPDATE because the register file acts on cmd
    // in that cycle, so bc seen in FIN is already the post-instruction value.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state  <= ST_IDLE;
            op_q   <= 8'h00;
            byte_q <= 8'h00;
            pv_q   <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start)
                op_q <= opcode;
            if (state == ST_READ && mem_ack)
                byte_q <= mem_din;
            if (state == ST_UPDATE) begin
                pv_q <= flag_calc[FLAG_PARITY];
                z_q  <= flag_calc[FLAG_ZERO];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = 16'h0000;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_dout  = 8'h00;
        cmd       = CMD_NOPE;
        flg_w     = 1'b0;
        flag      = 8'h00;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        rep       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = is_block_op(opcode) ? ST_READ : ST_FIN;
            end
            ST_READ: begin
                mem_addr = hl;
                mem_rd   = 1'b1;
                if (mem_ack)
                    state_nxt = op_q[OP_CP] ? ST_UPDATE : ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr = de;
                mem_dout = byte_q;
                mem_we   = 1'b1;
                if (mem_ack)
                    state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                cmd       = op_q[OP_DEC] ? CMD_DEC : CMD_INC;
                flg_w     = 1'b1;
                flag      = flag_calc;
                state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done      = 1'b1;
                rep       = is_block_op(op_q) && op_q[OP_REP] && pv_q
                            && (!op_q[OP_CP] || !z_q);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
